// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access stage: FSM states,
// default geometry and the MEM/WB bubble value.
package mem_stage_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam int ADDR_W_DEFAULT  = 18;
  localparam int TIMEOUT_DEFAULT = 255;
  localparam int CNT_W           = 8;

  typedef struct packed {
    logic [31:0] result;
    logic [3:0]  rg;
    logic        sel_c;
    logic        sel_v;
    logic        we_c;
    logic        prohib;
  } mem_wb_t;

  // A bubble is an annulled slot: nothing downstream may write back from it.
  localparam mem_wb_t MEM_WB_BUBBLE = '{
    result: 32'h0,
    rg:     4'h0,
    sel_c:  1'b0,
    sel_v:  1'b0,
    we_c:   1'b0,
    prohib: 1'b1
  };

endpackage

// File: rtl/reg_mem_wb.sv
// MEM/WB pipeline register. Loads either the stage result or a bubble every
// cycle; reset also leaves it holding a bubble.
module reg_mem_wb
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        bubble,
  input  logic [31:0] nxt_result,
  input  logic [3:0]  nxt_rg,
  input  logic        nxt_sel_c,
  input  logic        nxt_sel_v,
  input  logic        nxt_we_c,
  input  logic        nxt_prohib,
  output logic [31:0] wb_result,
  output logic [3:0]  Rg_wb,
  output logic        sel_c_wb,
  output logic        sel_v_wb,
  output logic        we_c_wb,
  output logic        prohib_wb
);

  mem_wb_t mem_wb_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_wb_p0 <= MEM_WB_BUBBLE;
    end else if (bubble) begin
      mem_wb_p0 <= MEM_WB_BUBBLE;
    end else begin
      mem_wb_p0 <= '{result: nxt_result, rg: nxt_rg, sel_c: nxt_sel_c,
                     sel_v: nxt_sel_v, we_c: nxt_we_c, prohib: nxt_prohib};
    end
  end

  assign wb_result = mem_wb_p0.result;
  assign Rg_wb     = mem_wb_p0.rg;
  assign sel_c_wb  = mem_wb_p0.sel_c;
  assign sel_v_wb  = mem_wb_p0.sel_v;
  assign we_c_wb   = mem_wb_p0.we_c;
  assign prohib_wb = mem_wb_p0.prohib;

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: byte load/store to the image buffer over req/ack,
// front-end stall while an access is outstanding, and the MEM/WB register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_mem,
  input  logic              sel_dat,
  input  logic              sel_c,
  input  logic              sel_v,
  input  logic              we_c,
  input  logic              prohib_mem,
  input  logic [31:0]       result,
  input  logic [7:0]        DoB_byte,
  input  logic [3:0]        Rg_mem,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic [31:0]       wb_result,
  output logic [3:0]        Rg_wb,
  output logic              sel_c_wb,
  output logic              sel_v_wb,
  output logic              we_c_wb,
  output logic              prohib_wb,
  output logic              mem_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             access;
  logic             timeout_hit;
  logic             bubble;
  logic [31:0]      wb_data;

  assign access = !prohib_mem && (we_mem || sel_dat);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (access) state_nxt = ACCESS;
      ACCESS:  if (mem_ack || (cnt == CNT_LAST)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A stalled cycle and an aborted access both write a bubble; only the
  // ack cycle (or a non-memory op) lets real data into MEM/WB.
  always_comb begin
    mem_req     = 1'b0;
    stall       = 1'b0;
    timeout_hit = 1'b0;
    bubble      = 1'b0;
    wb_data     = result;
    case (state)
      IDLE: begin
        stall  = access;
        bubble = access;
      end
      ACCESS: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          if (!mem_we) wb_data = {24'b0, mem_rdata};
        end else if (cnt == CNT_LAST) begin
          timeout_hit = 1'b1;
          bubble      = 1'b1;
        end else begin
          stall  = 1'b1;
          bubble = 1'b1;
        end
      end
      default: ;
    endcase
    if (rst) stall = 1'b0;
  end

  // Request fields are captured once at detection so they stay stable
  // for the whole handshake; a simultaneous load+store request is a store.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= 8'h00;
      cnt       <= '0;
      mem_err   <= 1'b0;
    end else begin
      if (state == IDLE && access) begin
        mem_addr  <= result[ADDR_W-1:0];
        mem_we    <= we_mem;
        mem_wdata <= DoB_byte;
        cnt       <= '0;
      end else if (state == ACCESS && !mem_ack) begin
        cnt <= cnt + 1'b1;
      end
      if (timeout_hit) mem_err <= 1'b1;
    end
  end

  reg_mem_wb u_reg_mem_wb (
    .clk        (clk),
    .rst        (rst),
    .bubble     (bubble),
    .nxt_result (wb_data),
    .nxt_rg     (Rg_mem),
    .nxt_sel_c  (sel_c),
    .nxt_sel_v  (sel_v),
    .nxt_we_c   (we_c),
    .nxt_prohib (prohib_mem),
    .wb_result  (wb_result),
    .Rg_wb      (Rg_wb),
    .sel_c_wb   (sel_c_wb),
    .sel_v_wb   (sel_v_wb),
    .we_c_wb    (we_c_wb),
    .prohib_wb  (prohib_wb)
  );

endmodule
